// File: rtl/mc_control.sv
// mc_control -- multicycle control unit for the MIPS-subset computer.
//
// Sequences each instruction through IF -> ID -> EX -> MEM -> WB.
// Drives the ALU function code (aluc), the datapath mux selects and the
// write strobes. Stalls in IF and MEM until the memory reports mem_ready.
//
// Optional feature: define ILLEGAL_TRAP_EN to trap undefined instructions.
// When it is defined, an undefined op/func in ID raises the sticky
// `illegal` flag and parks the FSM in HALT until reset. When it is not
// defined, an undefined instruction retires as a NOP and `illegal` is 0.
//
// Ports
//   clock      in  1  single clock, rising edge
//   reset      in  1  synchronous, active-high
//   op         in  6  IR[31:26]
//   func       in  6  IR[5:0]
//   z          in  1  ALU zero flag
//   mem_ready  in  1  memory finished the current access this cycle
//   aluc       out 4  ALU function code
//   alusrca    out 1  ALU A: 0 PC, 1 rs/shamt
//   shift      out 1  ALU A takes sa (shift instructions in EX)
//   alusrcb    out 2  ALU B: 00 rt, 01 4, 10 imm, 11 sext(imm)<<2
//   sext       out 1  1 sign-extend imm, 0 zero-extend
//   pcsrc      out 2  PC source: 00 ALU, 01 branch target, 10 rs, 11 jump
//   pc_wr      out 1  PC write strobe
//   ir_wr      out 1  IR write strobe
//   mem_rd     out 1  memory read request
//   mem_wr     out 1  memory write request
//   iord       out 1  memory address: 0 PC, 1 ALU out
//   reg_wr     out 1  register file write
//   regdst     out 1  1 rd, 0 rt
//   m2reg      out 1  1 memory data, 0 ALU out
//   jal        out 1  write PC+4 to $31
//   state      out 3  current FSM state (debug)
//   illegal    out 1  sticky undefined-instruction flag
module mc_control (
   input  logic       clock,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic [5:0] func,
   input  logic       z,
   input  logic       mem_ready,
   output logic [3:0] aluc,
   output logic       alusrca,
   output logic       shift,
   output logic [1:0] alusrcb,
   output logic       sext,
   output logic [1:0] pcsrc,
   output logic       pc_wr,
   output logic       ir_wr,
   output logic       mem_rd,
   output logic       mem_wr,
   output logic       iord,
   output logic       reg_wr,
   output logic       regdst,
   output logic       m2reg,
   output logic       jal,
   output logic [2:0] state,
   output logic       illegal
);

   typedef enum logic [2:0] {
      S_IF   = 3'd0,
      S_ID   = 3'd1,
      S_EX   = 3'd2,
      S_MEM  = 3'd3,
      S_WB   = 3'd4,
      S_HALT = 3'd5
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] FN_JR    = 6'b001000;

   state_t state_reg;
   state_t state_next;

   // ------------------------------------------------------------------
   // Instruction decode
   // ------------------------------------------------------------------
   logic       is_rtype;
   logic       is_jr;
   logic       is_j;
   logic       is_jal;
   logic       is_beq;
   logic       is_bne;
   logic       is_lw;
   logic       is_sw;
   logic       r_ok;
   logic [3:0] r_aluc;
   logic       r_shift;
   logic       imm_ok;
   logic [3:0] imm_aluc;
   logic       imm_sext;
   logic       defined;

   assign is_rtype = (op == OP_RTYPE);
   assign is_jr    = is_rtype && (func == FN_JR);
   assign is_j     = (op == OP_J);
   assign is_jal   = (op == OP_JAL);
   assign is_beq   = (op == OP_BEQ);
   assign is_bne   = (op == OP_BNE);
   assign is_lw    = (op == OP_LW);
   assign is_sw    = (op == OP_SW);

   // R-type ALU operations (jr is handled separately in ID)
   always_comb begin
      r_ok    = 1'b0;
      r_aluc  = 4'b0000;
      r_shift = 1'b0;
      case (func)
         6'b100000: begin r_ok = 1'b1; r_aluc = 4'b0000; end
         6'b100010: begin r_ok = 1'b1; r_aluc = 4'b0100; end
         6'b100100: begin r_ok = 1'b1; r_aluc = 4'b0001; end
         6'b100101: begin r_ok = 1'b1; r_aluc = 4'b0101; end
         6'b100110: begin r_ok = 1'b1; r_aluc = 4'b0010; end
         6'b000000: begin r_ok = 1'b1; r_aluc = 4'b0011; r_shift = 1'b1; end
         6'b000010: begin r_ok = 1'b1; r_aluc = 4'b0111; r_shift = 1'b1; end
         6'b000011: begin r_ok = 1'b1; r_aluc = 4'b1111; r_shift = 1'b1; end
         default:   begin r_ok = 1'b0; end
      endcase
   end

   // Immediate ALU operations; logical immediates zero-extend
   always_comb begin
      imm_ok   = 1'b0;
      imm_aluc = 4'b0000;
      imm_sext = 1'b0;
      case (op)
         6'b001000: begin imm_ok = 1'b1; imm_aluc = 4'b0000; imm_sext = 1'b1; end
         6'b001100: begin imm_ok = 1'b1; imm_aluc = 4'b0001; end
         6'b001101: begin imm_ok = 1'b1; imm_aluc = 4'b0101; end
         6'b001110: begin imm_ok = 1'b1; imm_aluc = 4'b0010; end
         6'b001111: begin imm_ok = 1'b1; imm_aluc = 4'b0110; end
         default:   begin imm_ok = 1'b0; end
      endcase
   end

   assign defined = (is_rtype && (r_ok || is_jr)) || imm_ok || is_lw || is_sw ||
                    is_beq || is_bne || is_j || is_jal;

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg <= S_IF;
      end else begin
         state_reg <= state_next;
      end
   end

   assign state = state_reg;

`ifdef ILLEGAL_TRAP_EN
   logic illegal_reg;

   always_ff @(posedge clock) begin
      if (reset) begin
         illegal_reg <= 1'b0;
      end else if (state_reg == S_ID && !defined) begin
         illegal_reg <= 1'b1;
      end
   end

   assign illegal = illegal_reg;
`else
   assign illegal = 1'b0;
`endif

   // ------------------------------------------------------------------
   // Next state and outputs
   // ------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      aluc       = 4'b0000;
      alusrca    = 1'b0;
      shift      = 1'b0;
      alusrcb    = 2'b00;
      sext       = 1'b0;
      pcsrc      = 2'b00;
      pc_wr      = 1'b0;
      ir_wr      = 1'b0;
      mem_rd     = 1'b0;
      mem_wr     = 1'b0;
      iord       = 1'b0;
      reg_wr     = 1'b0;
      regdst     = 1'b0;
      m2reg      = 1'b0;
      jal        = 1'b0;

      case (state_reg)
         S_IF: begin
            mem_rd = 1'b1;
            if (mem_ready) begin
               // Latch the instruction and advance PC by 4 in the same cycle
               ir_wr      = 1'b1;
               pc_wr      = 1'b1;
               alusrcb    = 2'b01;
               state_next = S_ID;
            end
         end

         S_ID: begin
            // ALU computes PC+4 + sext(imm)<<2 so EX can use it as the branch target
            alusrcb = 2'b11;
            if (is_j) begin
               pc_wr      = 1'b1;
               pcsrc      = 2'b11;
               state_next = S_IF;
            end else if (is_jal) begin
               pc_wr      = 1'b1;
               pcsrc      = 2'b11;
               reg_wr     = 1'b1;
               jal        = 1'b1;
               state_next = S_IF;
            end else if (is_jr) begin
               pc_wr      = 1'b1;
               pcsrc      = 2'b10;
               state_next = S_IF;
            end else if (defined) begin
               state_next = S_EX;
            end else begin
`ifdef ILLEGAL_TRAP_EN
               state_next = S_HALT;
`else
               // PC was already advanced in IF, so this retires as a NOP
               state_next = S_IF;
`endif
            end
         end

         S_EX: begin
            if (is_rtype) begin
               aluc       = r_aluc;
               shift      = r_shift;
               alusrca    = 1'b1;
               alusrcb    = 2'b00;
               state_next = S_WB;
            end else if (imm_ok) begin
               aluc       = imm_aluc;
               sext       = imm_sext;
               alusrca    = 1'b1;
               alusrcb    = 2'b10;
               state_next = S_WB;
            end else if (is_lw || is_sw) begin
               alusrca    = 1'b1;
               alusrcb    = 2'b10;
               sext       = 1'b1;
               state_next = S_MEM;
            end else if (is_beq || is_bne) begin
               aluc       = 4'b0100;
               alusrca    = 1'b1;
               alusrcb    = 2'b00;
               pcsrc      = 2'b01;
               pc_wr      = is_beq ? z : !z;
               state_next = S_IF;
            end else begin
               state_next = S_IF;
            end
         end

         S_MEM: begin
            iord   = 1'b1;
            mem_rd = is_lw;
            mem_wr = is_sw;
            if (mem_ready) begin
               state_next = is_lw ? S_WB : S_IF;
            end
         end

         S_WB: begin
            reg_wr     = 1'b1;
            regdst     = is_rtype;
            m2reg      = is_lw;
            state_next = S_IF;
         end

`ifdef ILLEGAL_TRAP_EN
         S_HALT: begin
            state_next = S_HALT;
         end
`endif

         default: begin
            state_next = S_IF;
         end
      endcase

      // A reset cycle aborts whatever was in flight: nothing may be written
      if (reset) begin
         pc_wr  = 1'b0;
         ir_wr  = 1'b0;
         mem_rd = 1'b0;
         mem_wr = 1'b0;
         reg_wr = 1'b0;
         jal    = 1'b0;
      end
   end

endmodule

// File: tb/tb_mc_control.sv
// Testbench for mc_control. Each scenario pushes one expectation per clock
// cycle (inputs for that cycle plus the required outputs and a field mask)
// into a scoreboard queue, then drains it: drive the inputs, sample outputs
// 1 ns later (well before the next rising edge), compare, step a cycle.
module tb_mc_control;

   logic       clock;
   logic       reset;
   logic [5:0] op;
   logic [5:0] func;
   logic       z;
   logic       mem_ready;
   logic [3:0] aluc;
   logic       alusrca;
   logic       shift;
   logic [1:0] alusrcb;
   logic       sext;
   logic [1:0] pcsrc;
   logic       pc_wr;
   logic       ir_wr;
   logic       mem_rd;
   logic       mem_wr;
   logic       iord;
   logic       reg_wr;
   logic       regdst;
   logic       m2reg;
   logic       jal;
   logic [2:0] state;
   logic       illegal;

   mc_control dut (
      .clock     (clock),
      .reset     (reset),
      .op        (op),
      .func      (func),
      .z         (z),
      .mem_ready (mem_ready),
      .aluc      (aluc),
      .alusrca   (alusrca),
      .shift     (shift),
      .alusrcb   (alusrcb),
      .sext      (sext),
      .pcsrc     (pcsrc),
      .pc_wr     (pc_wr),
      .ir_wr     (ir_wr),
      .mem_rd    (mem_rd),
      .mem_wr    (mem_wr),
      .iord      (iord),
      .reg_wr    (reg_wr),
      .regdst    (regdst),
      .m2reg     (m2reg),
      .jal       (jal),
      .state     (state),
      .illegal   (illegal)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct packed {
      logic [2:0] state;
      logic [3:0] aluc;
      logic       alusrca;
      logic       shift;
      logic [1:0] alusrcb;
      logic       sext;
      logic [1:0] pcsrc;
      logic       pc_wr;
      logic       ir_wr;
      logic       mem_rd;
      logic       mem_wr;
      logic       iord;
      logic       reg_wr;
      logic       regdst;
      logic       m2reg;
      logic       jal;
      logic       illegal;
   } ov_t;

   typedef struct {
      logic       rst;
      logic       rdy;
      logic [5:0] op;
      logic [5:0] fn;
      logic       z;
      ov_t        val;
      ov_t        msk;
      string      tag;
   } exp_t;

   ov_t  obs;
   assign obs = {state, aluc, alusrca, shift, alusrcb, sext, pcsrc, pc_wr, ir_wr,
                 mem_rd, mem_wr, iord, reg_wr, regdst, m2reg, jal, illegal};

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   // Instruction currently being stimulated; copied into each expectation
   logic [5:0] cur_op = 6'd0;
   logic [5:0] cur_fn = 6'd0;
   logic       cur_z  = 1'b0;

   // Base expectation: state plus every write strobe and the illegal flag
   // are always checked (unlisted strobes must be 0).
   function automatic exp_t mk(string tag, logic rst, logic rdy, logic [2:0] st);
      exp_t e;
      e.tag = tag; e.rst = rst; e.rdy = rdy;
      e.op = cur_op; e.fn = cur_fn; e.z = cur_z;
      e.val = '0;
      e.msk = '0;
      e.msk.state = '1;
      e.msk.pc_wr = 1'b1; e.msk.ir_wr = 1'b1; e.msk.mem_rd = 1'b1;
      e.msk.mem_wr = 1'b1; e.msk.reg_wr = 1'b1; e.msk.jal = 1'b1;
      e.msk.illegal = 1'b1;
      e.val.state = st;
      return e;
   endfunction

   function automatic exp_t e_if(string tag, logic rdy);
      exp_t e = mk(tag, 1'b0, rdy, 3'd0);
      e.val.mem_rd = 1'b1;
      e.msk.iord = 1'b1;
      if (rdy) begin
         e.val.ir_wr = 1'b1; e.val.pc_wr = 1'b1;
         e.msk.pcsrc = '1; e.msk.alusrca = 1'b1; e.msk.alusrcb = '1; e.msk.aluc = '1;
         e.val.alusrcb = 2'b01;
      end
      return e;
   endfunction

   function automatic exp_t e_id(string tag, logic rdy);
      exp_t e = mk(tag, 1'b0, rdy, 3'd1);
      e.msk.aluc = '1; e.msk.alusrca = 1'b1; e.msk.alusrcb = '1;
      e.val.alusrcb = 2'b11;
      return e;
   endfunction

   function automatic exp_t e_mem(string tag, logic rdy, logic is_lw);
      exp_t e = mk(tag, 1'b0, rdy, 3'd3);
      e.msk.iord = 1'b1; e.val.iord = 1'b1;
      e.val.mem_rd = is_lw; e.val.mem_wr = !is_lw;
      return e;
   endfunction

   function automatic exp_t e_wb(string tag, logic rd, logic m2);
      exp_t e = mk(tag, 1'b0, 1'b1, 3'd4);
      e.val.reg_wr = 1'b1;
      e.msk.regdst = 1'b1; e.msk.m2reg = 1'b1;
      e.val.regdst = rd; e.val.m2reg = m2;
      return e;
   endfunction

   task automatic test_reset();
      exp_t e;
      cur_op = 6'b000000; cur_fn = 6'b100000; cur_z = 1'b0;
      // mem_ready high in IF under reset must not fire ir_wr/pc_wr
      sb.push_back(mk("reset_c1", 1'b1, 1'b1, 3'd0));
      sb.push_back(mk("reset_c2", 1'b1, 1'b1, 3'd0));
      sb.push_back(e_if("if_stall_a", 1'b0));
      sb.push_back(e_if("if_stall_b", 1'b0));
      while (sb.size() > 0) begin
         e = sb.pop_front();
         reset = e.rst; mem_ready = e.rdy; op = e.op; func = e.fn; z = e.z;
         #1;
         checks++;
         if ((obs & e.msk) !== (e.val & e.msk)) begin
            errors++;
            $display("FAIL %s: got %h required %h (mask %h)", e.tag, obs & e.msk, e.val, e.msk);
         end
         @(negedge clock);
      end
   endtask

   task automatic test_add();
      exp_t e;
      cur_op = 6'b000000; cur_fn = 6'b100000; cur_z = 1'b0;
      sb.push_back(e_if("add_if", 1'b1));
      sb.push_back(e_id("add_id", 1'b1));
      e = mk("add_ex", 1'b0, 1'b1, 3'd2);
      e.msk.aluc = '1; e.msk.alusrca = 1'b1; e.msk.alusrcb = '1; e.msk.shift = 1'b1;
      e.val.aluc = 4'b0000; e.val.alusrca = 1'b1; e.val.alusrcb = 2'b00;
      sb.push_back(e);
      sb.push_back(e_wb("add_wb", 1'b1, 1'b0));
      while (sb.size() > 0) begin
         e = sb.pop_front();
         reset = e.rst; mem_ready = e.rdy; op = e.op; func = e.fn; z = e.z;
         #1;
         checks++;
         if ((obs & e.msk) !== (e.val & e.msk)) begin
            errors++;
            $display("FAIL %s: got %h required %h (mask %h)", e.tag, obs & e.msk, e.val, e.msk);
         end
         @(negedge clock);
      end
   endtask

   task automatic test_alu_ops();
      exp_t       e;
      logic [5:0] t_op [13] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
                                6'b001000, 6'b001100, 6'b001101, 6'b001110, 6'b001111};
      logic [5:0] t_fn [13] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110,
                                6'b000000, 6'b000010, 6'b000011,
                                6'h00, 6'h00, 6'h00, 6'h00, 6'h00};
      logic [3:0] t_alu [13] = '{4'b0000, 4'b0100, 4'b0001, 4'b0101, 4'b0010,
                                 4'b0011, 4'b0111, 4'b1111,
                                 4'b0000, 4'b0001, 4'b0101, 4'b0010, 4'b0110};
      logic       t_sx [13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      for (int i = 0; i < 13; i++) begin
         cur_op = t_op[i]; cur_fn = t_fn[i]; cur_z = i[0];
         sb.push_back(e_if($sformatf("alu%0d_if", i), 1'b1));
         sb.push_back(e_id($sformatf("alu%0d_id", i), 1'b0));
         e = mk($sformatf("alu%0d_ex op=%b fn=%b", i, t_op[i], t_fn[i]), 1'b0, 1'b1, 3'd2);
         e.msk.aluc = '1; e.msk.alusrca = 1'b1; e.msk.alusrcb = '1;
         e.val.aluc = t_alu[i]; e.val.alusrca = 1'b1;
         if (i < 8) begin
            e.msk.shift = 1'b1;
            e.val.shift = (i >= 5);
            e.val.alusrcb = 2'b00;
         end else begin
            e.val.alusrcb = 2'b10;
            if (i != 12) begin
               e.msk.sext = 1'b1;
               e.val.sext = t_sx[i];
            end
         end
         sb.push_back(e);
         sb.push_back(e_wb($sformatf("alu%0d_wb", i), (i < 8), 1'b0));
      end
      while (sb.size() > 0) begin
         e = sb.pop_front();
         reset = e.rst; mem_ready = e.rdy; op = e.op; func = e.fn; z = e.z;
         #1;
         checks++;
         if ((obs & e.msk) !== (e.val & e.msk)) begin
            errors++;
            $display("FAIL %s: got %h required %h (mask %h)", e.tag, obs & e.msk, e.val, e.msk);
         end
         @(negedge clock);
      end
   endtask

   task automatic test_mem();
      exp_t e;
      // lw with three not-ready cycles in MEM: 8 cycles total
      cur_op = 6'b100011; cur_fn = 6'b010101; cur_z = 1'b0;
      sb.push_back(e_if("lw_if", 1'b1));
      sb.push_back(e_id("lw_id", 1'b1));
      e = mk("lw_ex", 1'b0, 1'b1, 3'd2);
      e.msk.aluc = '1; e.msk.alusrcb = '1; e.msk.sext = 1'b1;
      e.val.aluc = 4'b0000; e.val.alusrcb = 2'b10; e.val.sext = 1'b1;
      sb.push_back(e);
      for (int i = 0; i < 3; i++) sb.push_back(e_mem($sformatf("lw_mem_wait%0d", i), 1'b0, 1'b1));
      sb.push_back(e_mem("lw_mem_ready", 1'b1, 1'b1));
      sb.push_back(e_wb("lw_wb", 1'b0, 1'b1));
      // sw with immediate ready returns to IF after MEM
      cur_op = 6'b101011;
      sb.push_back(e_if("sw_if", 1'b1));
      sb.push_back(e_id("sw_id", 1'b1));
      e = mk("sw_ex", 1'b0, 1'b0, 3'd2);
      e.msk.aluc = '1; e.msk.alusrcb = '1; e.msk.sext = 1'b1;
      e.val.aluc = 4'b0000; e.val.alusrcb = 2'b10; e.val.sext = 1'b1;
      sb.push_back(e);
      sb.push_back(e_mem("sw_mem", 1'b1, 1'b0));
      sb.push_back(e_if("sw_next_if", 1'b0));
      while (sb.size() > 0) begin
         e = sb.pop_front();
         reset = e.rst; mem_ready = e.rdy; op = e.op; func = e.fn; z = e.z;
         #1;
         checks++;
         if ((obs & e.msk) !== (e.val & e.msk)) begin
            errors++;
            $display("FAIL %s: got %h required %h (mask %h)", e.tag, obs & e.msk, e.val, e.msk);
         end
         @(negedge clock);
      end
   endtask

   task automatic test_branch();
      exp_t e;
      for (int k = 0; k < 4; k++) begin
         cur_op = (k < 2) ? 6'b000100 : 6'b000101;
         cur_fn = 6'b000000;
         cur_z  = k[0];
         sb.push_back(e_if($sformatf("br%0d_if", k), 1'b1));
         sb.push_back(e_id($sformatf("br%0d_id", k), 1'b1));
         e = mk($sformatf("br%0d_ex %s z=%0d", k, (k < 2) ? "beq" : "bne", k[0]), 1'b0, 1'b1, 3'd2);
         e.msk.aluc = '1; e.msk.alusrca = 1'b1; e.msk.alusrcb = '1; e.msk.pcsrc = '1;
         e.val.aluc = 4'b0100; e.val.alusrca = 1'b1; e.val.alusrcb = 2'b00; e.val.pcsrc = 2'b01;
         e.val.pc_wr = (k < 2) ? k[0] : !k[0];
         sb.push_back(e);
      end
      sb.push_back(e_if("br_done_if", 1'b0));
      while (sb.size() > 0) begin
         e = sb.pop_front();
         reset = e.rst; mem_ready = e.rdy; op = e.op; func = e.fn; z = e.z;
         #1;
         checks++;
         if ((obs & e.msk) !== (e.val & e.msk)) begin
            errors++;
            $display("FAIL %s: got %h required %h (mask %h)", e.tag, obs & e.msk, e.val, e.msk);
         end
         @(negedge clock);
      end
   endtask

   task automatic test_jump();
      exp_t e;
      // j
      cur_op = 6'b000010; cur_fn = 6'b111000; cur_z = 1'b0;
      sb.push_back(e_if("j_if", 1'b1));
      e = e_id("j_id", 1'b1);
      e.msk.pcsrc = '1; e.val.pcsrc = 2'b11; e.val.pc_wr = 1'b1;
      sb.push_back(e);
      // jal
      cur_op = 6'b000011;
      sb.push_back(e_if("jal_if", 1'b1));
      e = e_id("jal_id", 1'b0);
      e.msk.pcsrc = '1; e.val.pcsrc = 2'b11; e.val.pc_wr = 1'b1;
      e.val.reg_wr = 1'b1; e.val.jal = 1'b1;
      sb.push_back(e);
      // jr
      cur_op = 6'b000000; cur_fn = 6'b001000;
      sb.push_back(e_if("jr_if", 1'b1));
      e = e_id("jr_id", 1'b1);
      e.msk.pcsrc = '1; e.val.pcsrc = 2'b10; e.val.pc_wr = 1'b1;
      sb.push_back(e);
      sb.push_back(e_if("jr_next_if", 1'b0));
      while (sb.size() > 0) begin
         e = sb.pop_front();
         reset = e.rst; mem_ready = e.rdy; op = e.op; func = e.fn; z = e.z;
         #1;
         checks++;
         if ((obs & e.msk) !== (e.val & e.msk)) begin
            errors++;
            $display("FAIL %s: got %h required %h (mask %h)", e.tag, obs & e.msk, e.val, e.msk);
         end
         @(negedge clock);
      end
   endtask

   task automatic test_illegal();
      exp_t e;
      logic [5:0] u_op [2] = '{6'b111111, 6'b000000};
      logic [5:0] u_fn [2] = '{6'b000000, 6'b000001};
      for (int k = 0; k < 2; k++) begin
         cur_op = u_op[k]; cur_fn = u_fn[k]; cur_z = 1'b0;
         sb.push_back(e_if($sformatf("ill%0d_if", k), 1'b1));
         sb.push_back(e_id($sformatf("ill%0d_id", k), 1'b1));
`ifdef ILLEGAL_TRAP_EN
         for (int h = 0; h < 3; h++) begin
            e = mk($sformatf("ill%0d_halt%0d", k, h), 1'b0, 1'b1, 3'd5);
            e.val.illegal = 1'b1;
            sb.push_back(e);
         end
         e = mk($sformatf("ill%0d_halt_reset", k), 1'b1, 1'b1, 3'd5);
         e.msk.illegal = 1'b0;
         sb.push_back(e);
`endif
         sb.push_back(e_if($sformatf("ill%0d_after_if", k), 1'b0));
      end
      while (sb.size() > 0) begin
         e = sb.pop_front();
         reset = e.rst; mem_ready = e.rdy; op = e.op; func = e.fn; z = e.z;
         #1;
         checks++;
         if ((obs & e.msk) !== (e.val & e.msk)) begin
            errors++;
            $display("FAIL %s: got %h required %h (mask %h)", e.tag, obs & e.msk, e.val, e.msk);
         end
         @(negedge clock);
      end
   endtask

   task automatic test_reset_mid();
      exp_t e;
      cur_op = 6'b101011; cur_fn = 6'b000000; cur_z = 1'b0;
      sb.push_back(e_if("rmid_if", 1'b1));
      sb.push_back(e_id("rmid_id", 1'b1));
      e = mk("rmid_ex", 1'b0, 1'b0, 3'd2);
      e.msk.alusrcb = '1; e.val.alusrcb = 2'b10;
      sb.push_back(e);
      // reset while sw sits in MEM with memory ready: no mem_wr may fire
      sb.push_back(mk("rmid_mem_reset", 1'b1, 1'b1, 3'd3));
      sb.push_back(e_if("rmid_after_if", 1'b0));
      sb.push_back(e_if("rmid_after_if_go", 1'b1));
      sb.push_back(e_id("rmid_after_id", 1'b0));
      while (sb.size() > 0) begin
         e = sb.pop_front();
         reset = e.rst; mem_ready = e.rdy; op = e.op; func = e.fn; z = e.z;
         #1;
         checks++;
         if ((obs & e.msk) !== (e.val & e.msk)) begin
            errors++;
            $display("FAIL %s: got %h required %h (mask %h)", e.tag, obs & e.msk, e.val, e.msk);
         end
         @(negedge clock);
      end
   endtask

   initial begin
      reset     = 1'b1;
      mem_ready = 1'b0;
      op        = 6'd0;
      func      = 6'd0;
      z         = 1'b0;
      @(negedge clock);
      test_reset();
      test_add();
      test_alu_ops();
      test_mem();
      test_branch();
      test_jump();
      test_illegal();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
